operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode-to-execute stage that sits directly downstream of the 32x32 register file and consumes its two combinational read ports.
- Drives rs1/rs2 read addresses and resolves operands by forwarding from EX, MEM and WB.
- Stalls decode on unresolved load-use hazards.
- Registers resolved operands plus control into a single-entry valid/ready pipeline register feeding EX.

Parameters:
- CTRL_W, 16, width of opaque control payload carried decode->EX unchanged
- CNT_W, 32, width of stall-cycle performance counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of held and incoming instruction
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1 / in_rs2  in  5 each  source register indices
- in_use_rs1 / in_use_rs2  in  1 each  source actually read
- in_rd  in  5  destination index
- in_rd_we  in  1  instruction writes rd
- in_ctrl  in  CTRL_W  control payload
- rf_raddr1 / rf_raddr2  out  5 each  register file read addresses, combinationally equal to in_rs1 / in_rs2
- rf_rdata1 / rf_rdata2  in  32 each  register file read data
- ex_fwd_we  in  1  EX result valid this cycle
- ex_fwd_addr  in  5  EX destination
- ex_fwd_data  in  32  EX result
- ex_is_load  in  1  EX holds a load; ex_fwd_addr result not yet available
- mem_fwd_we  in  1  MEM result valid
- mem_fwd_addr  in  5  MEM destination
- mem_fwd_data  in  32  MEM result
- mem_pending  in  1  MEM load data not yet returned for mem_fwd_addr
- wb_we / wb_waddr / wb_wdata  in  1/5/32  same signals driving the register file write port
- out_valid  out  1  EX-side instruction valid
- out_ready  in  1  EX accepts
- out_op1 / out_op2  out  32 each  resolved operands
- out_rd / out_rd_we / out_ctrl  out  5/1/CTRL_W  registered copies
- stall_cycles  out  CNT_W  hazard-stall cycle counter

Behaviour:
- Reset low: out_valid=0, out_op1=out_op2=0, out_rd=0, out_rd_we=0, out_ctrl=0, stall_cycles=0, immediately and without waiting for a clock edge.
- Operand select per source, highest priority first:
  - index 0 -> 0, never forwarded
  - ex_fwd_we && ex_fwd_addr==idx -> ex_fwd_data
  - mem_fwd_we && match -> mem_fwd_data
  - wb_we && match -> wb_wdata (register file write lands at the edge, so the combinational read is stale)
  - otherwise rf_rdataN
- hazard = in_valid && any used nonzero source matching (ex_is_load && ex_fwd_addr) or (mem_pending && mem_fwd_addr).
  - A pending load match beats any lower-priority forward of the same index.
  - An unused source never hazards.
- in_ready = !hazard && (!out_valid || out_ready). Asserted even when in_valid=0, provided no hazard.
- Capture when in_valid && in_ready && !flush:
  - out_* <= resolved values; out_valid <= 1
  - latency 1 cycle, input to out_valid
- out_valid && out_ready with no capture -> out_valid <= 0.
- Back-to-back: hold and capture in the same cycle replaces the contents; full throughput, one instruction per cycle.
- Downstream stall (out_valid && !out_ready): all out_* hold, bit-stable.
- flush: out_valid <= 0 next edge. Incoming instruction dropped even if handshake fires. Counter unaffected. Priority over capture.
- stall_cycles increments by 1 each cycle hazard=1 and flush=0. Wraps modulo 2^CNT_W.
- Data fields are not cleared when out_valid drops; only out_valid is qualifying.
- Reset asserted mid-transfer: instruction lost, all outputs return to reset values.

Test Plan:
- Reset low with in_valid=1, rs1=3 -> out_valid=0, ops=0, stall_cycles=0. Release reset with r3=0x11 in the register file -> next cycle out_op1=0x11, out_valid=1.
- ex_fwd (r5=0xAAAA), mem_fwd (r5=0xBBBB) and wb (r5=0xCCCC) all active, rs1=rs2=5 -> out_op1=out_op2=0xAAAA. Drop EX -> 0xBBBB. Drop MEM -> 0xCCCC.
- rs1=0 with ex_fwd_we=1, ex_fwd_addr=0, data=0xDEAD -> out_op1=0.
- ex_is_load=1, ex_fwd_addr=7, rs2=7 used, held 2 cycles -> in_ready=0 for 2 cycles, stall_cycles=2. Then mem_fwd r7=0x1234 with no pending -> captured out_op2=0x1234. Repeat with in_use_rs2=0 -> no stall.
- out_ready=0 for 3 cycles while out_valid=1 -> out_* stable, in_ready=0. Then out_ready=1 with in_valid streaming 4 instructions -> 4 outputs on 4 consecutive cycles.
- flush asserted on the same cycle as an accept -> out_valid=0 next cycle, instruction absent. stall_cycles starting at 0xFFFFFFFF plus one hazard cycle -> wraps to 0.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Decode-to-execute pipeline bus: the decode-side request and the EX-side
// resolved-operand output, each with its own valid/ready handshake.
interface operand_fetch_if #(
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic [4:0]        in_rd;
    logic              in_rd_we;
    logic [CTRL_W-1:0] in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_op1;
    logic [31:0]       out_op2;
    logic [4:0]        out_rd;
    logic              out_rd_we;
    logic [CTRL_W-1:0] out_ctrl;

    // Master is the surrounding pipeline (decode drives, EX consumes).
    modport master (
        output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_we, in_ctrl,
        input  in_ready,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctrl,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_we, in_ctrl,
        output in_ready,
        output out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctrl,
        input  out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, forwards from EX/MEM/WB,
// stalls on load-use hazards and registers the result into a skid-free pipe stage.
module operand_fetch #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    operand_fetch_if.slave   bus,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [31:0]      rf_rdata1,
    input  logic [31:0]      rf_rdata2,
    input  logic             ex_fwd_we,
    input  logic [4:0]       ex_fwd_addr,
    input  logic [31:0]      ex_fwd_data,
    input  logic             ex_is_load,
    input  logic             mem_fwd_we,
    input  logic [4:0]       mem_fwd_addr,
    input  logic [31:0]      mem_fwd_data,
    input  logic             mem_pending,
    input  logic             wb_we,
    input  logic [4:0]       wb_waddr,
    input  logic [31:0]      wb_wdata,
    output logic [CNT_W-1:0] stall_cycles
);
    logic [1:0][4:0]  src_idx;
    logic [1:0][31:0] src_rf;
    logic [1:0]       src_use;
    logic [1:0][31:0] src_op;
    logic [1:0]       src_hazard;

    logic             hazard;
    logic             ready;
    logic             capture;

    logic              out_valid_q;
    logic [31:0]       op1_q;
    logic [31:0]       op2_q;
    logic [4:0]        rd_q;
    logic              rd_we_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  stall_q;

    assign rf_raddr1 = bus.in_rs1;
    assign rf_raddr2 = bus.in_rs2;

    assign src_idx = {bus.in_rs2, bus.in_rs1};
    assign src_rf  = {rf_rdata2, rf_rdata1};
    assign src_use = {bus.in_use_rs2, bus.in_use_rs1};

    // WB must still be forwarded: the register file write only lands at the
    // edge, so the combinational read returns the stale value this cycle.
    always_comb begin
        src_op     = '0;
        src_hazard = '0;
        for (int i = 0; i < 2; i++) begin
            if (src_idx[i] == 5'd0) begin
                src_op[i] = 32'd0;
            end else if (ex_fwd_we && ex_fwd_addr == src_idx[i]) begin
                src_op[i] = ex_fwd_data;
            end else if (mem_fwd_we && mem_fwd_addr == src_idx[i]) begin
                src_op[i] = mem_fwd_data;
            end else if (wb_we && wb_waddr == src_idx[i]) begin
                src_op[i] = wb_wdata;
            end else begin
                src_op[i] = src_rf[i];
            end

            if (src_use[i] && src_idx[i] != 5'd0 &&
                ((ex_is_load && ex_fwd_addr == src_idx[i]) ||
                 (mem_pending && mem_fwd_addr == src_idx[i]))) begin
                src_hazard[i] = 1'b1;
            end
        end
    end

    assign hazard  = bus.in_valid && (|src_hazard);
    assign ready   = !hazard && (!out_valid_q || bus.out_ready);
    assign capture = bus.in_valid && ready && !flush;

    // Flush wins over capture; data fields are left as-is when out_valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            ctrl_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            op1_q       <= src_op[0];
            op2_q       <= src_op[1];
            rd_q        <= bus.in_rd;
            rd_we_q     <= bus.in_rd_we;
            ctrl_q      <= bus.in_ctrl;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (hazard && !flush) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op1   = op1_q;
    assign bus.out_op2   = op2_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_rd_we = rd_we_q;
    assign bus.out_ctrl  = ctrl_q;
    assign stall_cycles  = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vectors, a transaction-level
// reference model compared every cycle, and hand-computed literal checkpoints.
module tb_operand_fetch;
    localparam int CTRL_W = 16;
    // Narrow counter so that wrap-around is reachable in a handful of cycles.
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [4:0]        rf_raddr1, rf_raddr2;
    logic [31:0]       rf_rdata1, rf_rdata2;
    logic              ex_fwd_we, ex_is_load;
    logic [4:0]        ex_fwd_addr;
    logic [31:0]       ex_fwd_data;
    logic              mem_fwd_we, mem_pending;
    logic [4:0]        mem_fwd_addr;
    logic [31:0]       mem_fwd_data;
    logic              wb_we;
    logic [4:0]        wb_waddr;
    logic [31:0]       wb_wdata;
    logic [CNT_W-1:0]  stall_cycles;

    logic [31:0]       rf [32];

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    logic              m_valid = 1'b0;
    logic [31:0]       m_op1   = '0;
    logic [31:0]       m_op2   = '0;
    logic [4:0]        m_rd    = '0;
    logic              m_rd_we = 1'b0;
    logic [CTRL_W-1:0] m_ctrl  = '0;
    logic [CNT_W-1:0]  m_stall = '0;

    operand_fetch_if #(.CTRL_W(CTRL_W)) bus ();

    operand_fetch #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .ex_fwd_we    (ex_fwd_we),
        .ex_fwd_addr  (ex_fwd_addr),
        .ex_fwd_data  (ex_fwd_data),
        .ex_is_load   (ex_is_load),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .mem_pending  (mem_pending),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Register file model: combinational reads, write lands at the clock edge.
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clk) if (wb_we) rf[wb_waddr] <= wb_wdata;

    function automatic logic [31:0] expOperand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (ex_fwd_we && ex_fwd_addr == idx) return ex_fwd_data;
        if (mem_fwd_we && mem_fwd_addr == idx) return mem_fwd_data;
        if (wb_we && wb_waddr == idx) return wb_wdata;
        return rf[idx];
    endfunction

    function automatic logic srcBlocked(input logic used, input logic [4:0] idx);
        return used && idx != 5'd0 &&
               ((ex_is_load && ex_fwd_addr == idx) || (mem_pending && mem_fwd_addr == idx));
    endfunction

    function automatic logic expHazard();
        return bus.in_valid && (srcBlocked(bus.in_use_rs1, bus.in_rs1) ||
                                srcBlocked(bus.in_use_rs2, bus.in_rs2));
    endfunction

    function automatic logic expReady();
        return !expHazard() && (!m_valid || bus.out_ready);
    endfunction

    // Reference model: what the EX side must hold after each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 1'b0; m_op1 = '0; m_op2 = '0;
            m_rd = '0; m_rd_we = 1'b0; m_ctrl = '0; m_stall = '0;
        end else begin
            logic hz, rdy;
            hz  = expHazard();
            rdy = expReady();
            if (flush) begin
                m_valid = 1'b0;
            end else if (bus.in_valid && rdy) begin
                m_valid = 1'b1;
                m_op1   = expOperand(bus.in_rs1);
                m_op2   = expOperand(bus.in_rs2);
                m_rd    = bus.in_rd;
                m_rd_we = bus.in_rd_we;
                m_ctrl  = bus.in_ctrl;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (hz && !flush) m_stall = m_stall + 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!done) begin
            checkOutput("out_valid", 64'(bus.out_valid), 64'(m_valid));
            checkOutput("stall_cycles", 64'(stall_cycles), 64'(m_stall));
            checkOutput("rf_raddr1", 64'(rf_raddr1), 64'(bus.in_rs1));
            checkOutput("rf_raddr2", 64'(rf_raddr2), 64'(bus.in_rs2));
            if (reset) checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady()));
            if (m_valid || !reset) begin
                checkOutput("out_op1", 64'(bus.out_op1), 64'(m_op1));
                checkOutput("out_op2", 64'(bus.out_op2), 64'(m_op2));
                checkOutput("out_rd", 64'(bus.out_rd), 64'(m_rd));
                checkOutput("out_rd_we", 64'(bus.out_rd_we), 64'(m_rd_we));
                checkOutput("out_ctrl", 64'(bus.out_ctrl), 64'(m_ctrl));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic use1,
                                 input logic [4:0] rs2, input logic use2,
                                 input logic [4:0] rd, input logic [CTRL_W-1:0] ctrl);
        bus.in_valid   = valid;
        bus.in_rs1     = rs1;
        bus.in_use_rs1 = use1;
        bus.in_rs2     = rs2;
        bus.in_use_rs2 = use2;
        bus.in_rd      = rd;
        bus.in_rd_we   = (rd != 5'd0);
        bus.in_ctrl    = ctrl;
    endtask

    task automatic clearForwarding();
        ex_fwd_we = 0; ex_fwd_addr = 0; ex_fwd_data = 0; ex_is_load = 0;
        mem_fwd_we = 0; mem_fwd_addr = 0; mem_fwd_data = 0; mem_pending = 0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[3] = 32'h11;
        rf[7] = 32'h77;
        clearForwarding();
        flush = 0;
        bus.out_ready = 1;
        reset = 0;
        applyStimulus(1, 5'd3, 1, 5'd0, 0, 5'd1, 16'h0001);

        // Reset holds everything at zero even with an instruction offered.
        step(); step();
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset out_op1", 64'(bus.out_op1), 64'd0);
        checkOutput("reset stall", 64'(stall_cycles), 64'd0);
        reset = 1;
        step();
        checkOutput("first out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("first out_op1", 64'(bus.out_op1), 64'h11);

        // Forwarding priority EX > MEM > WB.
        applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd2, 16'h0002);
        ex_fwd_we = 1;  ex_fwd_addr = 5;  ex_fwd_data = 32'hAAAA;
        mem_fwd_we = 1; mem_fwd_addr = 5; mem_fwd_data = 32'hBBBB;
        wb_we = 1;      wb_waddr = 5;     wb_wdata = 32'hCCCC;
        step();
        checkOutput("ex fwd op1", 64'(bus.out_op1), 64'hAAAA);
        checkOutput("ex fwd op2", 64'(bus.out_op2), 64'hAAAA);
        ex_fwd_we = 0;
        step();
        checkOutput("mem fwd op1", 64'(bus.out_op1), 64'hBBBB);
        mem_fwd_we = 0;
        step();
        checkOutput("wb fwd op2", 64'(bus.out_op2), 64'hCCCC);
        wb_we = 0;
        step();
        checkOutput("rf after wb", 64'(bus.out_op1), 64'hCCCC);

        // Register zero is never forwarded.
        applyStimulus(1, 5'd0, 1, 5'd5, 1, 5'd3, 16'h0003);
        ex_fwd_we = 1; ex_fwd_addr = 0; ex_fwd_data = 32'hDEAD;
        step();
        checkOutput("r0 op1", 64'(bus.out_op1), 64'd0);
        checkOutput("r0 op2", 64'(bus.out_op2), 64'hCCCC);

        // Load-use hazard on rs2 for two cycles, then MEM forward resolves it.
        clearForwarding();
        applyStimulus(1, 5'd0, 0, 5'd7, 1, 5'd4, 16'h0004);
        ex_is_load = 1; ex_fwd_addr = 7;
        #1;
        checkOutput("load-use in_ready", 64'(bus.in_ready), 64'd0);
        step();
        checkOutput("load-use stall 1", 64'(stall_cycles), 64'd1);
        step();
        checkOutput("load-use stall 2", 64'(stall_cycles), 64'd2);
        checkOutput("load-use no valid", 64'(bus.out_valid), 64'd0);
        ex_is_load = 0; ex_fwd_addr = 0;
        mem_fwd_we = 1; mem_fwd_addr = 7; mem_fwd_data = 32'h1234;
        #1;
        checkOutput("resolved in_ready", 64'(bus.in_ready), 64'd1);
        step();
        checkOutput("mem fwd op2", 64'(bus.out_op2), 64'h1234);

        // Unused source never hazards.
        clearForwarding();
        ex_is_load = 1; ex_fwd_addr = 7;
        applyStimulus(1, 5'd0, 0, 5'd7, 0, 5'd5, 16'h0005);
        step();
        checkOutput("unused stall", 64'(stall_cycles), 64'd2);
        checkOutput("unused op2", 64'(bus.out_op2), 64'h77);

        // Downstream backpressure for three cycles.
        clearForwarding();
        applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd9, 16'h00A1);
        step();
        bus.out_ready = 0;
        applyStimulus(1, 5'd4, 1, 5'd2, 1, 5'd9, 16'h00A2);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bp in_ready", 64'(bus.in_ready), 64'd0);
            step();
            checkOutput("bp op1", 64'(bus.out_op1), 64'h101);
            checkOutput("bp ctrl", 64'(bus.out_ctrl), 64'h00A1);
        end

        // Full-throughput stream once EX accepts again.
        bus.out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 5'(10 + k), 1, 5'd2, 1, 5'd9, 16'(16'h00B0 + k));
            step();
            checkOutput("stream valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stream ctrl", 64'(bus.out_ctrl), 64'(16'h00B0 + k));
            checkOutput("stream op1", 64'(bus.out_op1), 64'(32'h10A + k));
        end
        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 16'h0000);
        step();
        checkOutput("drain valid", 64'(bus.out_valid), 64'd0);
        checkOutput("idle in_ready", 64'(bus.in_ready), 64'd1);

        // Flush on an accepting cycle drops the instruction; data not cleared.
        applyStimulus(1, 5'd6, 1, 5'd0, 0, 5'd6, 16'h00C0);
        flush = 1;
        step();
        checkOutput("flush accept valid", 64'(bus.out_valid), 64'd0);
        checkOutput("flush keeps ctrl", 64'(bus.out_ctrl), 64'h00B3);

        // Flush squashes a held instruction.
        flush = 0; bus.out_ready = 0;
        applyStimulus(1, 5'd6, 1, 5'd0, 0, 5'd6, 16'h00D0);
        step();
        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 16'h0000);
        flush = 1;
        step();
        checkOutput("flush held valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1;

        // Hazard under flush is not counted.
        ex_is_load = 1; ex_fwd_addr = 7;
        applyStimulus(1, 5'd0, 0, 5'd7, 1, 5'd1, 16'h00E0);
        step();
        checkOutput("flush stall", 64'(stall_cycles), 64'd2);

        // Counter wraps modulo 2^CNT_W: 14 more hazard cycles from 2 -> 0.
        flush = 0;
        for (int k = 0; k < 14; k++) step();
        checkOutput("stall wrap", 64'(stall_cycles), 64'd0);
        step();
        checkOutput("stall after wrap", 64'(stall_cycles), 64'd1);

        // Reset in the middle of a transfer discards everything immediately.
        clearForwarding();
        applyStimulus(1, 5'd3, 1, 5'd1, 1, 5'd8, 16'h00F0);
        step();
        checkOutput("pre-reset valid", 64'(bus.out_valid), 64'd1);
        #1 reset = 0;
        #1;
        checkOutput("async reset valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async reset op2", 64'(bus.out_op2), 64'd0);
        checkOutput("async reset ctrl", 64'(bus.out_ctrl), 64'd0);
        checkOutput("async reset stall", 64'(stall_cycles), 64'd0);
        step();
        reset = 1;
        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 16'h0000);
        step(); step();

        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
